adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined successor to the 30-bit combinational adder in the high-speed arithmetic library. It splits a WIDTH-bit add into STAGES carry-chained segments, one segment per clock, so long carry paths close timing at high frequency. A valid/ready handshake with full backpressure lets it drop into streaming datapaths. It also reports carry-out and signed overflow, and can optionally saturate.

## Interface
- WIDTH, 30: operand and result width in bits. Range 2..128.
- STAGES, 3: number of pipeline segments, which is also the latency. Range 1..WIDTH.
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- in_valid in 1: operand beat present.
- in_ready out 1: block accepts the beat this cycle.
- A in WIDTH: operand A, two's complement.
- B in WIDTH: operand B, two's complement.
- CIN in 1: carry-in.
- out_valid out 1: result beat present.
- out_ready in 1: downstream accepts the result.
- C out WIDTH: sum.
- COUT out 1: unsigned carry-out of the full-width add.
- OVF out 1: signed overflow of A+B+CIN.

## Operation
- Segment width SEG = ceil(WIDTH/STAGES). Segment k covers bits [k·SEG, min((k+1)·SEG, WIDTH)−1]. The last segment may be narrower. Empty segments are not allowed; the parameter check fails elaboration if any would exist.
- Stage k adds segment k of A and B plus the carry registered by stage k−1. Stage 0 uses CIN as its carry-in.
- Higher operand segments travel in skew registers alongside the pipeline until their stage is reached. Completed low result segments travel forward the same way.
- COUT is the carry out of the top segment.
- OVF = (A[W−1] == B[W−1]) && (S[W−1] != A[W−1]), where S is the raw sum.
- Per-stage valid bits vld[0..STAGES−1]. out_valid = vld[STAGES−1].
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- On adv, every stage loads from the stage before it, and vld[0] loads in_valid. Bubbles are not collapsed; the pipeline moves as a single shift register.
- When adv=0, all stage registers, C, COUT and OVF hold. A, B and CIN are ignored that cycle.
- Results come out in input order. No beat is dropped or duplicated.
- Reset: all vld bits go to 0, and C, COUT and OVF go to 0. out_valid=0. in_ready=1 from the first cycle after rst_n deasserts. Asserting reset mid-operation discards every in-flight beat.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, provided there is no stall.
- Throughput: one beat per clock while out_ready=1.
- Combinational in_ready path: out_ready→in_ready is combinational. No other input-to-output combinational path exists.
- Critical path: one SEG-bit add plus the carry register.
- Simultaneous accept and emit while full: legal. The output beat leaves and a new beat enters on the same edge.
- STAGES=1: the block degenerates to a single registered adder with latency 1.

## Configuration
- ADDER_PIPE_SAT_EN defined:
  - When OVF=1, C saturates to the signed limit. This is 0x1FFFFFFF-style max (0 followed by ones) when A is non-negative, and min (1 followed by zeros) otherwise.
  - OVF still reports the overflow.
  - COUT is unaffected.
- Not defined: C is the wrapped WIDTH-bit sum. The saturation mux is absent from the netlist.

## Structure
- Package adder_pkg holds:
  - the function seg_width(WIDTH, STAGES);
  - localparam helpers for segment low/high bit indices;
  - the signed max/min constants as functions of WIDTH.
- Sub-module adder_seg computes a SEG-bit sum plus carry-out from carry-in, purely combinationally. It is instantiated once per stage, and each stage registers its output.
- The top level adder_pipe owns the valid shift, the skew registers, the flag logic and the optional saturation.

## Test plan
All scenarios use WIDTH=30, STAGES=3.
- Basic sums, back-to-back with out_ready=1 and CIN=0. Each result appears 3 cycles after acceptance.
  - 31 + (−31) → C=0, COUT=1, OVF=0.
  - 0 + 0 → C=0, COUT=0.
  - 16 + 8 → C=24.
  - (−8) + (−9) → C=−17 (30'h3FFFFFEF), COUT=1, OVF=0.
- Segment carry ripple: 30'h3FFFFFFF + 0 with CIN=1 → C=0, COUT=1. This checks the carry crossing both segment boundaries.
- Overflow: 30'h1FFFFFFF + 1 → OVF=1.
  - Without the macro: C=30'h20000000.
  - With ADDER_PIPE_SAT_EN: C=30'h1FFFFFFF.
  - (−16) + (−16) → C=−32, OVF=0.
- Backpressure:
  - Stream 8 beats (values 15+16, 14+(−16), …) while toggling out_ready with a random 50% pattern.
  - Check in_ready==(!out_valid||out_ready) every cycle.
  - Check outputs are in order, with none lost or duplicated, and C holds stable while out_valid && !out_ready.
- Reset mid-flight: accept 3 beats, then pulse rst_n low asynchronously between edges. out_valid and C go to 0 immediately. After release, no stale beat appears, and the next beat returns in 3 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for adder_pipe: segment geometry and signed saturation limits.
package adder_pkg;

   function automatic int seg_width(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   function automatic int seg_lo(input int k, input int seg);
      return k * seg;
   endfunction

   // The top segment is clipped to the operand width and may be narrower.
   function automatic int seg_hi(input int k, input int seg, input int width);
      return ((k + 1) * seg < width) ? (k + 1) * seg - 1 : width - 1;
   endfunction

   function automatic logic [127:0] sat_max(input int width);
      return {128{1'b1}} >> (129 - width);
   endfunction

   function automatic logic [127:0] sat_min(input int width);
      return 128'h1 << (width - 1);
   endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry-chained segment of the pipelined adder: W-bit sum plus carry-out.
// Latency: purely combinational, registered by the caller.
// Backpressure: none, holds no state.
module adder_seg #(
   parameter int W = 10
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, one SEG-bit segment per stage; ADDER_PIPE_SAT_EN adds saturation.
// Latency: STAGES cycles, one beat per clock.
// Backpressure: whole pipe stalls as one shift register when out_valid && !out_ready.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH  = 30,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             COUT,
   output logic             OVF
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   if (WIDTH < 2 || WIDTH > 128 || STAGES < 1 || STAGES > WIDTH ||
       SEG * (STAGES - 1) >= WIDTH) begin : g_param_err
      $error("adder_pipe: WIDTH/STAGES out of range or leaves an empty segment");
   end

   logic [STAGES-1:0] vld;
   logic              adv;

   assign out_valid = vld[STAGES-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   // Bubbles are kept: the valid bits shift in lock-step with the data stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (adv) begin
         vld[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            vld[k] <= vld[k-1];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = seg_lo(k, SEG);
      localparam int HI = seg_hi(k, SEG, WIDTH);
      localparam int SW = HI - LO + 1;

      logic [WIDTH-1:0] a_i, b_i, s_i, s_nxt;
      logic             c_i, c_o;
      logic [SW-1:0]    seg_s;

      if (k == 0) begin : g_in
         assign a_i = A;
         assign b_i = B;
         assign s_i = '0;
         assign c_i = CIN;
      end else begin : g_in
         assign a_i = g_stage[k-1].g_reg.a_q;
         assign b_i = g_stage[k-1].g_reg.b_q;
         assign s_i = g_stage[k-1].g_reg.s_q;
         assign c_i = g_stage[k-1].g_reg.cy_q;
      end

      adder_seg #(
         .W(SW)
      ) u_seg (
         .a   (a_i[HI:LO]),
         .b   (b_i[HI:LO]),
         .cin (c_i),
         .sum (seg_s),
         .cout(c_o)
      );

      // Segment bits of the partial sum are still zero here, so OR merges cleanly.
      assign s_nxt = s_i | (WIDTH'(seg_s) << LO);

      if (k < STAGES - 1) begin : g_reg
         logic [WIDTH-1:0] a_q, b_q, s_q;
         logic             cy_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q  <= '0;
               b_q  <= '0;
               s_q  <= '0;
               cy_q <= 1'b0;
            end else if (adv) begin
               a_q  <= a_i;
               b_q  <= b_i;
               s_q  <= s_nxt;
               cy_q <= c_o;
            end
         end
      end else begin : g_out
         logic             ovf_nxt;
         logic [WIDTH-1:0] c_nxt;

         assign ovf_nxt = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (s_nxt[WIDTH-1] != a_i[WIDTH-1]);

`ifdef ADDER_PIPE_SAT_EN
         localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
         localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
         assign c_nxt = !ovf_nxt ? s_nxt : (a_i[WIDTH-1] ? SMIN : SMAX);
`else
         assign c_nxt = s_nxt;
`endif

         // Operand bits below the top segment were consumed by earlier stages.
         if (k > 0) begin : g_low
            logic unused_low;
            assign unused_low = ^{a_i[LO-1:0], b_i[LO-1:0]};
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               C    <= '0;
               COUT <= 1'b0;
               OVF  <= 1'b0;
            end else if (adv) begin
               C    <= c_nxt;
               COUT <= c_o;
               OVF  <= ovf_nxt;
            end
         end
      end
   end

endmodule
